// File: rtl/reservoir_history_reader.sv
// Streams a window of the reservoir history RAM out over AXI-Stream through a 2-entry FIFO.
// Define RESERVOIR_READER_TLAST_EN to add the m_axis_tlast port.
module reservoir_history_reader #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_samples,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef RESERVOIR_READER_TLAST_EN
  output logic                  m_axis_tlast,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      sent_q, sent_d;
  logic                  rvalid_q;
  logic                  rlast_q, rlast_d;

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [1:0]            last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic                  ren_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  push_c;
  logic                  pop_c;
  logic [1:0]            occ_c;

  assign push_c = rvalid_q;
  assign pop_c  = (count_q != 2'd0) && m_axis_tready;
  // Entries held plus the read still in flight; never exceeds the FIFO depth.
  assign occ_c  = 2'(count_q + 2'(rvalid_q));

  // Next-state, read issue and counter update.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    total_d  = total_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    ren_c    = 1'b0;
    addr_c   = 2'(0) == 2'd0 ? ADDR_WIDTH'(base_q + issued_q[ADDR_WIDTH-1:0]) : '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = start_addr;
          total_d  = num_samples;
          issued_d = '0;
          sent_d   = '0;
          state_d  = ST_RUN;
          addr_c   = start_addr;
          // First read goes out with the request so data lands two cycles later.
          if (num_samples != '0) begin
            ren_c    = 1'b1;
            issued_d = CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if ((issued_q < total_q) && ((occ_c < 2'd2) || pop_c)) begin
          ren_c    = 1'b1;
          issued_d = issued_q + CNT_W'(1);
        end
        if (pop_c) begin
          sent_d = sent_q + CNT_W'(1);
        end
        if ((total_q == '0) || (pop_c && (sent_d == total_q))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rlast_d = ren_c && (issued_d == total_d);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state and counters.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      total_q  <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      total_q  <= total_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      rvalid_q <= ren_c;
      rlast_q  <= rlast_d;
    end
  end

  // Output FIFO; a read returning right after reset is dropped because rvalid_q is cleared.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push_c) begin
        data_q[wr_ptr_q] <= ram_dout;
        last_q[wr_ptr_q] <= rlast_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign ram_ren       = S_AXI_ARESETN && ren_c;
  assign ram_addr      = ram_ren ? addr_c : '0;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = data_q[rd_ptr_q];
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
`ifdef RESERVOIR_READER_TLAST_EN
  assign m_axis_tlast  = m_axis_tvalid && last_q[rd_ptr_q];
`endif

endmodule
